core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Two-phase FETCH/EXEC controller for the 8-bit accumulator core. It owns the PC and
//  issues it to program memory. It gates the decoder clock enables (Reg/Carry/Accu/DataMem)
//  so they fire only in EXEC, and handles jumps, a halt instruction and single-step debug.
//  It also arbitrates program-memory access between the core and an external program loader.
// PARAMETERS
//  ADDR_W    5   PC / program-memory address width
//  RESET_PC  0   PC value after Reset and after a completed load
// PORTS
//  clk         in   1       clock, rising edge
//  Reset       in   1       synchronous, active-high
//  Run         in   1       level; 1 = free-run instructions
//  StepReq     in   1       1-cycle pulse; execute exactly one instruction while stopped
//  StepAck     out  1       1-cycle pulse, in the EXEC cycle of the stepped instruction
//  ID_RegCE    in   1       decoder enable, ungated
//  ID_CarryCE  in   1       decoder enable, ungated
//  ID_AccuCE   in   1       decoder enable, ungated
//  ID_MemCE    in   1       decoder enable, ungated
//  JumpEn      in   1       decoder: current instruction is a taken jump
//  JumpAddr    in   ADDR_W  jump target
//  HaltIns     in   1       decoder: current instruction is HALT
//  LdReq       in   1       loader requests program memory (level, held for whole load)
//  LdGnt       out  1       memory granted to loader; core frozen
//  PC_Addr     out  ADDR_W  program-memory address
//  IR_Load     out  1       capture instruction register (FETCH)
//  RegCE       out  1       gated enable
//  CarryCE     out  1       gated enable
//  AccuCE      out  1       gated enable
//  MemCE       out  1       gated enable
//  Halted      out  1       sticky; HALT executed
// BEHAVIOUR
//  - Reset (any state, any cycle): next edge -> IDLE, PC=RESET_PC, Halted=0.
//    After reset, all CE/IR_Load/StepAck/LdGnt outputs are 0.
//  - FSM states: IDLE, FETCH, EXEC, LOAD. Only one transition per cycle.
//  - IDLE priority: LdReq > StepReq > (Run & !Halted).
//    LdReq -> LOAD. StepReq -> FETCH with step flag set. Run -> FETCH. Otherwise stay.
//  - FETCH: IR_Load=1 for exactly 1 cycle; PC stable -> EXEC.
//  - EXEC: each gated CE = ID_*CE for exactly 1 cycle. StepAck = step flag.
//    PC next: HaltIns ? PC : JumpEn ? JumpAddr : PC+1, modulo 2^ADDR_W (wraps max->0).
//    HaltIns has priority over JumpEn. HaltIns also sets Halted and suppresses all CEs.
//  - EXEC exit: LdReq -> LOAD; else HaltIns | step flag | !Run -> IDLE; else -> FETCH.
//    The step flag clears on leaving EXEC.
//  - Throughput: 1 instruction / 2 cycles. CE-to-register-update latency is 1 edge.
//  - LOAD: LdGnt=1, all CEs=0, PC frozen. LdReq falls -> IDLE, PC=RESET_PC, Halted=0.
//  - The loader is granted only at an instruction boundary (IDLE or end of EXEC).
//    LdReq asserted in FETCH waits for EXEC to finish.
//  - Halted=1 blocks Run. StepReq still works from IDLE and clears Halted.
//  - StepReq while not in IDLE is ignored (not queued). Run dropping mid-instruction
//    completes the instruction, then -> IDLE.
//  - Outputs are registered or decoded from state only; no combinational in->out path
//    except the gated CEs (state==EXEC & ID_*CE).
// STRUCTURE
//  - Shared package core_ctrl_pkg: seq_state_t enum {IDLE,FETCH,EXEC,LOAD},
//    PC_W default constant.
//  - Sub-module seq_pc_reg: PC register with sync clear / load / increment / hold,
//    parameterised by ADDR_W and RESET_PC.
//  - Top level: FSM, step flag, Halted flop, CE gating.
// TESTING
//  - Reset, Run=1, no jumps: PC 0,0,1,1,2 ... (2 cycles each). 31 -> 0 wrap.
//    IR_Load alternates with CE pulses.
//  - JumpEn=1, JumpAddr=5'd20 in EXEC at PC=3: next FETCH at PC=20; no PC=4 cycle.
//  - HaltIns at PC=7: CEs=0 that cycle, Halted=1, PC stays 7, IDLE.
//    Run held 1 keeps it in IDLE; StepReq -> executes PC=7 again, StepAck 1 cycle,
//    Halted cleared.
//  - Run=0, StepReq pulse at PC=2 with ID_AccuCE=1: exactly one AccuCE pulse,
//    PC -> 3, back to IDLE.
//  - LdReq rises during FETCH at PC=9: EXEC completes, then LdGnt=1, CEs 0.
//    LdReq falls -> PC=0, Halted=0, IDLE.
//  - Reset asserted during EXEC with ID_RegCE=1: next edge PC=0, RegCE=0, IDLE.
//    Simultaneous LdReq & StepReq in IDLE: LOAD wins, StepAck never pulses.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the accumulator core control path.
package core_ctrl_pkg;

    localparam int PC_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        LOAD
    } seq_state_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Decoder / program-memory bus between the sequencer and the datapath.
interface core_sequencer_if
    import core_ctrl_pkg::*;
#(
    parameter int ADDR_W = PC_W
);

    logic [ADDR_W-1:0] PC_Addr;
    logic              IR_Load;
    logic              ID_RegCE;
    logic              ID_CarryCE;
    logic              ID_AccuCE;
    logic              ID_MemCE;
    logic              JumpEn;
    logic [ADDR_W-1:0] JumpAddr;
    logic              HaltIns;
    logic              RegCE;
    logic              CarryCE;
    logic              AccuCE;
    logic              MemCE;

    // Sequencer side
    modport master (
        output PC_Addr, IR_Load, RegCE, CarryCE, AccuCE, MemCE,
        input  ID_RegCE, ID_CarryCE, ID_AccuCE, ID_MemCE, JumpEn, JumpAddr, HaltIns
    );

    // Decoder / datapath side
    modport slave (
        input  PC_Addr, IR_Load, RegCE, CarryCE, AccuCE, MemCE,
        output ID_RegCE, ID_CarryCE, ID_AccuCE, ID_MemCE, JumpEn, JumpAddr, HaltIns
    );

endinterface

// File: rtl/seq_pc_reg.sv
// Program counter: sync clear > load > increment > hold. Increment wraps.
module seq_pc_reg
    import core_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = PC_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    // PC update with priority clear, load, increment
    always_ff @(posedge clk) begin
        if (clr) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Two-phase FETCH/EXEC controller: owns the PC, gates decoder enables into
// EXEC, handles jump/halt/single-step and hands program memory to the loader
// only at instruction boundaries.
module core_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = PC_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              StepReq,
    output logic              StepAck,
    input  logic              LdReq,
    output logic              LdGnt,
    output logic              Halted,
    core_sequencer_if.master  bus
);

    seq_state_t        state;
    logic              step_flag;
    logic [ADDR_W-1:0] pc;
    logic              pc_clr;
    logic              pc_load;
    logic              pc_inc;
    logic              exec_live;

    // A halting instruction keeps the PC and fires no enables.
    assign exec_live = (state == EXEC) && !bus.HaltIns;

    assign pc_clr  = Reset || ((state == LOAD) && !LdReq);
    assign pc_load = exec_live && bus.JumpEn;
    assign pc_inc  = exec_live && !bus.JumpEn;

    seq_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .clr      (pc_clr),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (bus.JumpAddr),
        .pc       (pc)
    );

    // Sequencer FSM with step flag and sticky halt
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= IDLE;
            step_flag <= 1'b0;
            Halted    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (LdReq) begin
                        state <= LOAD;
                    end else if (StepReq) begin
                        state     <= FETCH;
                        step_flag <= 1'b1;
                        Halted    <= 1'b0;
                    end else if (Run && !Halted) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state <= EXEC;
                end
                EXEC: begin
                    step_flag <= 1'b0;
                    if (bus.HaltIns) begin
                        Halted <= 1'b1;
                    end
                    if (LdReq) begin
                        state <= LOAD;
                    end else if (bus.HaltIns || step_flag || !Run) begin
                        state <= IDLE;
                    end else begin
                        state <= FETCH;
                    end
                end
                LOAD: begin
                    if (!LdReq) begin
                        state  <= IDLE;
                        Halted <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.PC_Addr = pc;
    assign bus.IR_Load = (state == FETCH);
    assign LdGnt       = (state == LOAD);
    assign StepAck     = (state == EXEC) && step_flag;

    assign bus.RegCE   = exec_live && bus.ID_RegCE;
    assign bus.CarryCE = exec_live && bus.ID_CarryCE;
    assign bus.AccuCE  = exec_live && bus.ID_AccuCE;
    assign bus.MemCE   = exec_live && bus.ID_MemCE;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: a cycle model pushes expected
// outputs to a scoreboard each cycle, plus directed scenario checks.
module tb_core_sequencer;
    import core_ctrl_pkg::*;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic Reset, Run, StepReq, StepAck, LdReq, LdGnt, Halted;

    core_sequencer_if #(.ADDR_W(AW)) bus ();

    core_sequencer #(
        .ADDR_W   (AW),
        .RESET_PC (0)
    ) dut (
        .clk     (clk),
        .Reset   (Reset),
        .Run     (Run),
        .StepReq (StepReq),
        .StepAck (StepAck),
        .LdReq   (LdReq),
        .LdGnt   (LdGnt),
        .Halted  (Halted),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic          ir;
        logic [3:0]    ce;
        logic          ack;
        logic          gnt;
        logic          halted;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    seq_state_t    m_state;
    logic [AW-1:0] m_pc;
    logic          m_halted, m_step;

    seq_state_t    s_state;
    logic [AW-1:0] s_pc;
    logic          s_ir, s_reg, s_accu, s_ack, s_gnt, s_halted;
    logic [3:0]    s_ce;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        logic live;
        live     = (m_state == EXEC) && !bus.HaltIns;
        e.pc     = m_pc;
        e.ir     = (m_state == FETCH);
        e.ce     = live ? {bus.ID_RegCE, bus.ID_CarryCE, bus.ID_AccuCE, bus.ID_MemCE} : 4'b0000;
        e.ack    = (m_state == EXEC) && m_step;
        e.gnt    = (m_state == LOAD);
        e.halted = m_halted;
        return e;
    endfunction

    task automatic model_advance();
        if (Reset) begin
            m_state = IDLE; m_pc = '0; m_halted = 1'b0; m_step = 1'b0;
        end else begin
            case (m_state)
                IDLE: begin
                    if (LdReq) m_state = LOAD;
                    else if (StepReq) begin
                        m_state = FETCH; m_step = 1'b1; m_halted = 1'b0;
                    end else if (Run && !m_halted) m_state = FETCH;
                end
                FETCH: m_state = EXEC;
                EXEC: begin
                    if (bus.HaltIns) m_halted = 1'b1;
                    else if (bus.JumpEn) m_pc = bus.JumpAddr;
                    else m_pc = m_pc + 1'b1;
                    if (LdReq) m_state = LOAD;
                    else if (bus.HaltIns || m_step || !Run) m_state = IDLE;
                    else m_state = FETCH;
                    m_step = 1'b0;
                end
                LOAD: begin
                    if (!LdReq) begin
                        m_state = IDLE; m_pc = '0; m_halted = 1'b0;
                    end
                end
                default: m_state = IDLE;
            endcase
        end
    endtask

    // One clock: push expectation, sample mid-low-phase, compare, advance model.
    task automatic cycle();
        exp_t e;
        sb.push_back(predict());
        s_state = m_state;
        #2;
        s_pc     = bus.PC_Addr;
        s_ir     = bus.IR_Load;
        s_ce     = {bus.RegCE, bus.CarryCE, bus.AccuCE, bus.MemCE};
        s_reg    = bus.RegCE;
        s_accu   = bus.AccuCE;
        s_ack    = StepAck;
        s_gnt    = LdGnt;
        s_halted = Halted;
        e = sb.pop_front();
        check("sb_pc", s_pc, e.pc);
        check("sb_ir", s_ir, e.ir);
        check("sb_ce", s_ce, e.ce);
        check("sb_ack", s_ack, e.ack);
        check("sb_gnt", s_gnt, e.gnt);
        check("sb_halted", s_halted, e.halted);
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic set_dec(input logic [3:0] ce);
        {bus.ID_RegCE, bus.ID_CarryCE, bus.ID_AccuCE, bus.ID_MemCE} = ce;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
    endtask

    task automatic do_step();
        StepReq = 1'b1;
        cycle();
        StepReq = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen4, hit, acks, accus, found;
        logic [AW-1:0] prev_fetch;

        Reset = 1'b1; Run = 1'b0; StepReq = 1'b0; LdReq = 1'b0;
        bus.JumpEn = 1'b0; bus.JumpAddr = '0; bus.HaltIns = 1'b0;
        set_dec(4'b1111);
        @(negedge clk);
        @(posedge clk);
        m_state = IDLE; m_pc = '0; m_halted = 1'b0; m_step = 1'b0;
        @(negedge clk);

        // Reset state with decoder enables held high
        do_reset();
        cycle();
        check("rst_pc", s_pc, 0);
        check("rst_ce", s_ce, 0);
        check("rst_ir", s_ir, 0);
        check("rst_gnt", s_gnt, 0);
        check("rst_ack", s_ack, 0);
        check("rst_halted", s_halted, 0);

        // Free run: 0,0,1,1,... and wrap 31 -> 0
        do_reset();
        Run = 1'b1;
        for (int k = 0; k < 68; k++) begin
            cycle();
            if (k >= 1) begin
                check("run_pc", s_pc, ((k - 1) >> 1) & 31);
                check("run_ir", s_ir, k % 2);
                check("run_ce", s_reg, (k >= 2) && (k % 2 == 0));
            end
        end

        // Jump at PC=3 to 20
        do_reset();
        seen4 = 0; hit = 0; prev_fetch = '1;
        bus.JumpAddr = 5'd20;
        for (int k = 0; k < 16; k++) begin
            bus.JumpEn = (m_state == EXEC) && (m_pc == 3);
            cycle();
            if (s_ir) begin
                if (s_pc == 4) seen4++;
                if (prev_fetch == 3) begin
                    check("jump_tgt", s_pc, 20);
                    hit = 1;
                end
                prev_fetch = s_pc;
            end
        end
        bus.JumpEn = 1'b0;
        check("jump_seen", hit, 1);
        check("jump_no_pc4", seen4, 0);

        // Halt at PC=7, Run stays high, then single-step resumes
        do_reset();
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            bus.HaltIns = (m_state == EXEC) && (m_pc == 7);
            cycle();
            if (s_state == EXEC && s_pc == 7) begin
                check("halt_ce", s_ce, 0);
                found = 1;
            end
        end
        check("halt_reached", found, 1);
        bus.HaltIns = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("halt_pc", s_pc, 7);
            check("halt_flag", s_halted, 1);
            check("halt_ir", s_ir, 0);
        end
        StepReq = 1'b1;
        cycle();
        StepReq = 1'b0;
        acks = s_ack;
        cycle();
        acks += s_ack;
        check("halt_step_pc", s_pc, 7);
        check("halt_step_clr", s_halted, 0);
        cycle();
        acks += s_ack;
        cycle();
        acks += s_ack;
        check("halt_step_next", s_pc, 8);
        check("halt_step_acks", acks, 1);

        // Stopped single-step: AccuCE fires once at PC=2
        Run = 1'b0;
        do_reset();
        set_dec(4'b0000);
        do_step();
        do_step();
        check("step_start_pc", s_pc, 2);
        set_dec(4'b0010);
        accus = 0; acks = 0;
        StepReq = 1'b1;
        cycle();
        StepReq = 1'b0;
        accus += s_accu; acks += s_ack;
        for (int k = 0; k < 5; k++) begin
            cycle();
            accus += s_accu; acks += s_ack;
        end
        check("step_accu", accus, 1);
        check("step_ack", acks, 1);
        check("step_pc", s_pc, 3);
        check("step_idle", s_ir, 0);

        // Loader request during FETCH at PC=9
        do_reset();
        set_dec(4'b1111);
        Run = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (m_state == FETCH && m_pc == 9) found = 1;
            else cycle();
        end
        check("ld_reached", found, 1);
        LdReq = 1'b1;
        cycle();
        check("ld_fetch_gnt", s_gnt, 0);
        cycle();
        check("ld_exec_ce", s_reg, 1);
        check("ld_exec_gnt", s_gnt, 0);
        cycle();
        check("ld_gnt", s_gnt, 1);
        check("ld_ce", s_ce, 0);
        check("ld_pc", s_pc, 10);
        cycle();
        LdReq = 1'b0;
        cycle();
        cycle();
        check("ld_done_pc", s_pc, 0);
        check("ld_done_gnt", s_gnt, 0);
        check("ld_done_halted", s_halted, 0);
        check("ld_done_ir", s_ir, 0);

        // Reset while in EXEC with RegCE requested
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (m_state == EXEC && m_pc >= 2) found = 1;
            else cycle();
        end
        check("rexec_reached", found, 1);
        Reset = 1'b1;
        cycle();
        check("rexec_ce_live", s_reg, 1);
        Reset = 1'b0;
        Run = 1'b0;
        cycle();
        check("rexec_pc", s_pc, 0);
        check("rexec_ce", s_reg, 0);
        check("rexec_ir", s_ir, 0);

        // LdReq and StepReq together in IDLE: LOAD wins
        acks = 0;
        LdReq = 1'b1; StepReq = 1'b1;
        cycle();
        StepReq = 1'b0;
        acks += s_ack;
        cycle();
        acks += s_ack;
        check("both_gnt", s_gnt, 1);
        LdReq = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            acks += s_ack;
        end
        check("both_no_ack", acks, 0);
        check("both_pc", s_pc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
